// File: rtl/wave_pkg.sv
// Shared definitions for the 8-bit waveform datapath.
// Contents:
//   WAVE_* : waveform codes understood by wave_shaper
//   WAVE_W, STEP_W and the seg_w/step_lsb/wave_lsb helpers : layout of one
//            segment entry {wave, step, duration}; duration sits in the low
//            DURW bits. The host register map uses the same helpers.
//   seq_state_t : sequencer state, also exported as a debug signal.
package wave_pkg;

  localparam logic [2:0] WAVE_SAW       = 3'd0;
  localparam logic [2:0] WAVE_REVSAW    = 3'd1;
  localparam logic [2:0] WAVE_TRI       = 3'd2;
  localparam logic [2:0] WAVE_MEANDER   = 3'd3;
  localparam logic [2:0] WAVE_MEANDER25 = 3'd4;

  localparam int WAVE_W = 3;
  localparam int STEP_W = 8;

  function automatic int seg_w(input int durw);
    return WAVE_W + STEP_W + durw;
  endfunction

  function automatic int step_lsb(input int durw);
    return durw;
  endfunction

  function automatic int wave_lsb(input int durw);
    return durw + STEP_W;
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/wave_sequencer_if.sv
// Host/DAC-side bundle of the waveform sequencer.
// Signals:
//   cfg_we/cfg_addr/cfg_wdata : segment table write port (any time)
//   start, stop, loop_en      : sequence control
//   busy, seg_idx, wave_out   : playback status and sample bus
//   seg_done, done            : per-segment and end-of-sequence pulses
//   dbg_state                 : current sequencer state
// Handshake: start is a one-cycle request accepted only while busy=0 and
// stop=0; the first sample appears with busy=1 on the following cycle.
// stop is honoured only while busy=1 and returns to idle on the next cycle
// without a done pulse. done is a one-cycle pulse after a normal finish.
interface wave_sequencer_if #(
  parameter int NSEG = 4,
  parameter int DURW = 16
);
  import wave_pkg::*;

  localparam int AW = $clog2(NSEG);

  logic                     cfg_we;
  logic [AW-1:0]            cfg_addr;
  logic [seg_w(DURW)-1:0]   cfg_wdata;
  logic                     start;
  logic                     stop;
  logic                     loop_en;
  logic                     busy;
  logic [AW-1:0]            seg_idx;
  logic [7:0]               wave_out;
  logic                     seg_done;
  logic                     done;
  seq_state_t               dbg_state;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, start, stop, loop_en,
    input  busy, seg_idx, wave_out, seg_done, done, dbg_state
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, start, stop, loop_en,
    output busy, seg_idx, wave_out, seg_done, done, dbg_state
  );

endinterface

// File: rtl/wave_shaper.sv
// Combinational waveform shaper: {wave code, 8-bit phase} -> 8-bit sample.
// Ports:
//   wave   in  3  waveform code (WAVE_*), unused codes give 8'h00
//   phase  in  8  accumulator phase
//   sample out 8  shaped sample
module wave_shaper
  import wave_pkg::*;
(
  input  logic [2:0] wave,
  input  logic [7:0] phase,
  output logic [7:0] sample
);

  always_comb begin
    sample = 8'h00;
    case (wave)
      WAVE_SAW:       sample = phase;
      WAVE_REVSAW:    sample = ~phase;
      // Doubled phase folded back on the upper half of the period.
      WAVE_TRI:       sample = phase[7] ? ~{phase[6:0], 1'b0} : {phase[6:0], 1'b0};
      WAVE_MEANDER:   sample = (phase < 8'd128) ? 8'hFF : 8'h00;
      WAVE_MEANDER25: sample = (phase < 8'd64)  ? 8'hFF : 8'h00;
      default:        sample = 8'h00;
    endcase
  end

endmodule

// File: rtl/wave_sequencer.sv
// Segment sequencer for the 8-bit waveform datapath.
// Plays a table of NSEG segments {wave, step, duration} in order through a
// phase accumulator and drives one registered sample bus.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous, active-high
//   bus    wave_sequencer_if.slave : table write port, start/stop/loop_en,
//          busy, seg_idx, wave_out, seg_done, done, dbg_state
module wave_sequencer
  import wave_pkg::*;
#(
  parameter int NSEG = 4,
  parameter int DURW = 16
) (
  input  logic               clk,
  input  logic               reset,
  wave_sequencer_if.slave    bus
);

  localparam int AW  = $clog2(NSEG);
  localparam int SW  = seg_w(DURW);
  localparam int SLB = step_lsb(DURW);
  localparam int WLB = wave_lsb(DURW);

  logic [SW-1:0]   tbl [NSEG];

  seq_state_t      state;
  logic [2:0]      cur_wave;
  logic [7:0]      cur_step;
  logic [7:0]      phase;      // phase of the next sample to be shown
  logic [DURW-1:0] cnt;        // samples left in the segment, including the one on the bus
  logic [AW-1:0]   seg_idx_q;
  logic            busy_q;
  logic            seg_done_q;
  logic            done_q;
  logic [7:0]      wave_q;

  logic [AW-1:0]   nxt_idx;
  logic [AW-1:0]   ld_idx;
  logic            last_seg;
  logic [SW-1:0]   ld_entry;
  logic [2:0]      ld_wave;
  logic [7:0]      ld_step;
  logic [DURW-1:0] ld_dur;
  logic [7:0]      run_sample;
  logic [7:0]      ld_sample;
  logic            do_load;
  logic            do_idle;
  logic            do_finish;

  // Segment table. Reads of an entry being written in the same cycle see the
  // old contents because the write lands at the clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSEG; i++) tbl[i] <= '0;
    end else if (bus.cfg_we) begin
      tbl[bus.cfg_addr] <= bus.cfg_wdata;
    end
  end

  // Entry to load next: the following segment while the table continues,
  // otherwise entry 0 (sequence start or loop wrap).
  always_comb begin
    nxt_idx  = seg_idx_q + 1'b1;
    last_seg = (seg_idx_q == AW'(NSEG - 1)) || (tbl[nxt_idx][DURW-1:0] == '0);
    ld_idx   = (state == ST_RUN && !last_seg) ? nxt_idx : '0;
    ld_entry = tbl[ld_idx];
    ld_wave  = ld_entry[WLB +: WAVE_W];
    ld_step  = ld_entry[SLB +: STEP_W];
    ld_dur   = ld_entry[DURW-1:0];
  end

  wave_shaper u_run_shaper (
    .wave   (cur_wave),
    .phase  (phase),
    .sample (run_sample)
  );

  // A freshly loaded segment always starts at phase 0.
  wave_shaper u_load_shaper (
    .wave   (ld_wave),
    .phase  (8'h00),
    .sample (ld_sample)
  );

  always_comb begin
    do_load   = 1'b0;
    do_idle   = 1'b0;
    do_finish = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          if (ld_dur == '0) do_finish = 1'b1;
          else              do_load   = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          do_idle = 1'b1;
        end else if (cnt == DURW'(1)) begin
          // A loop wrap onto an emptied entry 0 finishes instead of stalling.
          if (!last_seg || (bus.loop_en && ld_dur != '0)) begin
            do_load = 1'b1;
          end else begin
            do_idle   = 1'b1;
            do_finish = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cur_wave   <= '0;
      cur_step   <= '0;
      phase      <= '0;
      cnt        <= '0;
      seg_idx_q  <= '0;
      busy_q     <= 1'b0;
      seg_done_q <= 1'b0;
      done_q     <= 1'b0;
      wave_q     <= 8'h00;
    end else begin
      done_q <= do_finish;
      if (do_load) begin
        state      <= ST_RUN;
        busy_q     <= 1'b1;
        seg_idx_q  <= ld_idx;
        cur_wave   <= ld_wave;
        cur_step   <= ld_step;
        wave_q     <= ld_sample;
        phase      <= ld_step;
        cnt        <= ld_dur;
        seg_done_q <= (ld_dur == DURW'(1));
      end else if (do_idle) begin
        state      <= ST_IDLE;
        busy_q     <= 1'b0;
        seg_idx_q  <= '0;
        wave_q     <= 8'h00;
        phase      <= '0;
        cnt        <= '0;
        seg_done_q <= 1'b0;
      end else if (state == ST_RUN) begin
        cnt        <= cnt - 1'b1;
        wave_q     <= run_sample;
        phase      <= phase + cur_step;
        seg_done_q <= (cnt == DURW'(2));
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.seg_idx   = seg_idx_q;
  assign bus.wave_out  = wave_q;
  assign bus.seg_done  = seg_done_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state;

endmodule
